bus_str_ser: RTL and testbench
==============================

Name: bus_str_ser

Overview:
Parametrised bus-to-stream serialiser and the successor of the fixed 32-bit to 8-bit bus/stream path.
- Accepts valid/ready bus writes, buffers them in a small FIFO, and emits each word as BDW/SDW stream chunks.
- Chunk order is selectable.
- Word-end and start-of-frame markers are added; a start of frame is flagged on address discontinuity.
- Sits between a bus master and stream consumers (e.g. link or packer blocks).

Parameters:
- BDW, 32: bus data width; must be an integer multiple of SDW.
- SDW, 8: stream data width; N = BDW/SDW chunks per word (N >= 1).
- AW, 32: bus address width.
- DEPTH, 4: FIFO depth in words; power of two, >= 2.
- MSB_FIRST, 0: 0 = least-significant chunk first; 1 = most-significant chunk first.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low (0 = reset asserted)
- bsi_vld  in  1  bus write valid
- bsi_adr  in  AW  bus write address
- bsi_dat  in  BDW  bus write data
- bsi_rdy  out  1  bus ready; transfer when bsi_vld & bsi_rdy
- str_vld  out  1  stream valid
- str_bus  out  SDW  stream data chunk
- str_sof  out  1  start of frame, qualified by str_vld; only on chunk 0
- str_eow  out  1  end of word, qualified by str_vld; only on chunk N-1
- str_rdy  in  1  stream ready; transfer when str_vld & str_rdy
- cnt  out  $clog2(DEPTH)+1  FIFO occupancy in words

Behaviour:
- Reset state (rst=0, asynchronous): FIFO pointers, cnt and chunk index are 0; last_adr is 0; first flag is 1.
- Reset outputs: bsi_rdy=0, str_vld=0, str_sof=0, str_eow=0, cnt=0. str_bus is don't-care.
- Ready: after reset release, bsi_rdy = (cnt != DEPTH), combinational from registered cnt. There is no pass-through when full.
- Push: on a bus transfer, store {dat, sof} at the write pointer.
  - sof = first | (bsi_adr != last_adr+1), with mod 2^AW arithmetic, so all-ones to 0 counts as contiguous.
  - Then last_adr <= bsi_adr and first <= 0.
- Latency: a word accepted at edge k makes str_vld=1 in the cycle after edge k (1-cycle latency).
- Stream valid: str_vld = (cnt != 0). str_bus, str_sof and str_eow are a combinational mux of the FIFO head entry and the chunk index idx (0..N-1).
- Chunk select:
  - MSB_FIRST=0: chunk = dat[idx*SDW +: SDW].
  - MSB_FIRST=1: chunk = dat[BDW-1-idx*SDW -: SDW].
- Stream flags: str_sof = head.sof & (idx==0); str_eow = (idx==N-1).
- Stream transfer:
  - If idx<N-1: idx <= idx+1.
  - If idx==N-1: idx <= 0 and the head word is popped (read pointer +1).
  - With N=1 every chunk carries eow, and sof per word.
- Stall: while str_vld & !str_rdy, str_bus/str_sof/str_eow hold stable (head and idx unchanged).
- Simultaneous push and pop in one cycle: cnt is unchanged and both pointers advance.
- Pointers: wrap modulo DEPTH; full/empty are derived from cnt.
- Mid-operation reset: any partially sent word is discarded; idx=0 and the FIFO is empty; the next word after release carries sof=1.
- Backpressure: cnt never exceeds DEPTH; no data is lost or duplicated under any pattern of bsi_vld or str_rdy.

Test Plan:
- Defaults, release rst, write adr 0 dat 0x44332211, str_rdy=1 -> str_bus 0x11,0x22,0x33,0x44 on 4 consecutive cycles starting 1 cycle after acceptance; sof on 0x11, eow on 0x44; cnt returns to 0.
- MSB_FIRST=1, same write -> 0x44,0x33,0x22,0x11; sof on 0x44, eow on 0x11.
- str_rdy=0, offer 5 words (adr 0..4) -> 4 accepted, cnt=4, bsi_rdy=0, 5th held. Raise str_rdy -> 16 chunks in order; 5th word accepted once cnt<4; total 20 chunks, none lost.
- Addresses 0,1,5,6 -> sof only on words at 0 and 5. Addresses 0xFFFFFFFF then 0x00000000 -> sof on first only.
- str_rdy toggling 1,0,1,0 during word 0xDDCCBBAA -> str_bus stable through each stall; 4 chunks over 8 cycles.
- Assert rst after 2 chunks of a word with 2 words queued -> str_vld=0, cnt=0 immediately (asynchronous). After release, write 0x12345678 at adr 9 -> chunks 0x78,0x56,0x34,0x12 with sof=1.
- SDW=32, BDW=32 -> one chunk per word with sof (first word) and eow both asserted.

Source files
------------

// File: rtl/bus_str_ser.sv
// Bus-to-stream serialiser: valid/ready bus writes are buffered in a small FIFO and
// emitted as BDW/SDW stream chunks with start-of-frame and end-of-word markers.
module bus_str_ser #(
    parameter int BDW       = 32,
    parameter int SDW       = 8,
    parameter int AW        = 32,
    parameter int DEPTH     = 4,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     bsi_vld,
    input  logic [AW-1:0]            bsi_adr,
    input  logic [BDW-1:0]           bsi_dat,
    output logic                     bsi_rdy,
    output logic                     str_vld,
    output logic [SDW-1:0]           str_bus,
    output logic                     str_sof,
    output logic                     str_eow,
    input  logic                     str_rdy,
    output logic [$clog2(DEPTH):0]   cnt
);

    localparam int N  = BDW / SDW;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic [AW-1:0]  last_adr_q, last_adr_d;
    logic           first_q, first_d;

    logic [BDW-1:0] mem_dat_q [DEPTH];
    logic           mem_sof_q [DEPTH];

    logic           push;
    logic           pop_chunk;
    logic           last_chunk;
    logic           pop;
    logic           new_sof;
    logic [IW-1:0]  sel;
    logic [BDW-1:0] head_dat;
    logic [BDW-1:0] shifted;

    // Ready is forced low while reset is held so no write is taken during reset.
    assign bsi_rdy    = rst & (cnt_q != CNT_FULL);
    assign str_vld    = (cnt_q != '0);
    assign push       = bsi_vld & bsi_rdy;
    assign pop_chunk  = str_vld & str_rdy;
    assign last_chunk = (idx_q == IDX_LAST);
    assign pop        = pop_chunk & last_chunk;
    assign new_sof    = first_q | (bsi_adr != last_adr_q + AW'(1));

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        last_adr_d = last_adr_q;
        first_d    = first_q;

        if (push) begin
            wr_ptr_d   = wr_ptr_q + PW'(1);
            last_adr_d = bsi_adr;
            first_d    = 1'b0;
        end

        if (pop_chunk) begin
            idx_d = last_chunk ? '0 : idx_q + IW'(1);
        end

        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end

        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            idx_q      <= '0;
            last_adr_q <= '0;
            first_q    <= 1'b1;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            last_adr_q <= last_adr_d;
            first_q    <= first_d;
        end
    end

    // Storage needs no reset: entries are only read while cnt marks them valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_dat_q[wr_ptr_q] <= bsi_dat;
            mem_sof_q[wr_ptr_q] <= new_sof;
        end
    end

    assign head_dat = mem_dat_q[rd_ptr_q];
    assign sel      = MSB_FIRST ? (IDX_LAST - idx_q) : idx_q;
    assign shifted  = head_dat >> (int'(sel) * SDW);

    assign str_bus  = shifted[SDW-1:0];
    assign str_sof  = str_vld & mem_sof_q[rd_ptr_q] & (idx_q == '0);
    assign str_eow  = str_vld & last_chunk;
    assign cnt      = cnt_q;

endmodule

// File: tb/tb_bus_str_ser.sv
// Scoreboard bench for bus_str_ser: three instances (LSB-first, MSB-first, one chunk
// per word) share the bus/stream stimulus; each has its own reference model queue.
module tb_bus_str_ser;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        bsi_vld = 1'b0;
    logic [31:0] bsi_adr = '0;
    logic [31:0] bsi_dat = '0;
    logic        str_rdy = 1'b0;

    logic        rdy_w [3];
    logic        vld_w [3];
    logic        sof_w [3];
    logic        eow_w [3];
    logic [2:0]  cnt_w [3];
    logic [7:0]  bus0, bus1;
    logic [31:0] bus2;

    int n_vec = 0;
    int n_bad = 0;

    logic [33:0] exp_q [3][$];
    logic        first_m [3];
    logic [31:0] last_m [3];
    int          words_in [3];
    int          words_out [3];
    int          chunks_out [3];
    logic        prev_stall [3];
    logic [31:0] prev_bus [3];
    logic        prev_sof [3];
    logic        prev_eow [3];

    always #5 clk = ~clk;

    bus_str_ser #(.BDW(32), .SDW(8), .AW(32), .DEPTH(4), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst(rst), .bsi_vld(bsi_vld), .bsi_adr(bsi_adr), .bsi_dat(bsi_dat),
        .bsi_rdy(rdy_w[0]), .str_vld(vld_w[0]), .str_bus(bus0), .str_sof(sof_w[0]),
        .str_eow(eow_w[0]), .str_rdy(str_rdy), .cnt(cnt_w[0]));

    bus_str_ser #(.BDW(32), .SDW(8), .AW(32), .DEPTH(4), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst(rst), .bsi_vld(bsi_vld), .bsi_adr(bsi_adr), .bsi_dat(bsi_dat),
        .bsi_rdy(rdy_w[1]), .str_vld(vld_w[1]), .str_bus(bus1), .str_sof(sof_w[1]),
        .str_eow(eow_w[1]), .str_rdy(str_rdy), .cnt(cnt_w[1]));

    bus_str_ser #(.BDW(32), .SDW(32), .AW(32), .DEPTH(4), .MSB_FIRST(1'b0)) u_wide (
        .clk(clk), .rst(rst), .bsi_vld(bsi_vld), .bsi_adr(bsi_adr), .bsi_dat(bsi_dat),
        .bsi_rdy(rdy_w[2]), .str_vld(vld_w[2]), .str_bus(bus2), .str_sof(sof_w[2]),
        .str_eow(eow_w[2]), .str_rdy(str_rdy), .cnt(cnt_w[2]));

    function automatic int nch(input int g);
        return (g == 2) ? 1 : 4;
    endfunction

    function automatic logic [31:0] chunk_of(input int g, input logic [31:0] w, input int i);
        case (g)
            0:       return (w >> (8 * i)) & 32'hFF;
            1:       return (w >> (8 * (3 - i))) & 32'hFF;
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] bus_of(input int g);
        case (g)
            0:       return {24'b0, bus0};
            1:       return {24'b0, bus1};
            default: return bus2;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int g = 0; g < 3; g++) begin
            exp_q[g].delete();
            first_m[g]   = 1'b1;
            last_m[g]    = '0;
            words_in[g]  = 0;
            words_out[g] = 0;
        end
    endtask

    // Input side: every accepted write becomes its expected chunk sequence.
    initial begin
        logic s;
        forever begin
            @(negedge clk);
            if (rst) begin
                for (int g = 0; g < 3; g++) begin
                    if (bsi_vld && rdy_w[g]) begin
                        s = first_m[g] || (bsi_adr != last_m[g] + 32'd1);
                        for (int i = 0; i < nch(g); i++)
                            exp_q[g].push_back({s && (i == 0), i == nch(g) - 1, chunk_of(g, bsi_dat, i)});
                        first_m[g] = 1'b0;
                        last_m[g]  = bsi_adr;
                        words_in[g]++;
                    end
                end
            end
        end
    end

    // Output side: occupancy, handshakes, stall stability and popped chunks.
    initial begin
        logic [33:0] e;
        logic [31:0] b;
        logic        acc;
        int          ec;
        forever begin
            @(negedge clk);
            #1;
            for (int g = 0; g < 3; g++) begin
                if (!rst) begin
                    prev_stall[g] = 1'b0;
                end else begin
                    acc = bsi_vld && rdy_w[g];
                    ec  = words_in[g] - words_out[g] - (acc ? 1 : 0);
                    b   = bus_of(g);
                    check($sformatf("cnt[%0d]", g), 32'(cnt_w[g]), 32'(ec));
                    check($sformatf("bsi_rdy[%0d]", g), 32'(rdy_w[g]), 32'(ec != 4));
                    check($sformatf("str_vld[%0d]", g), 32'(vld_w[g]), 32'(ec != 0));
                    if (prev_stall[g] && vld_w[g]) begin
                        check($sformatf("stall_bus[%0d]", g), b, prev_bus[g]);
                        check($sformatf("stall_sof[%0d]", g), 32'(sof_w[g]), 32'(prev_sof[g]));
                        check($sformatf("stall_eow[%0d]", g), 32'(eow_w[g]), 32'(prev_eow[g]));
                    end
                    prev_stall[g] = vld_w[g] && !str_rdy;
                    prev_bus[g]   = b;
                    prev_sof[g]   = sof_w[g];
                    prev_eow[g]   = eow_w[g];
                    if (vld_w[g] && str_rdy) begin
                        if (exp_q[g].size() == 0) begin
                            n_vec++;
                            n_bad++;
                            $display("FAIL pop[%0d]: chunk 0x%0h with nothing expected", g, b);
                        end else begin
                            e = exp_q[g].pop_front();
                            check($sformatf("str_bus[%0d]", g), b, e[31:0]);
                            check($sformatf("str_sof[%0d]", g), 32'(sof_w[g]), 32'(e[33]));
                            check($sformatf("str_eow[%0d]", g), 32'(eow_w[g]), 32'(e[32]));
                            if (e[32]) words_out[g]++;
                            chunks_out[g]++;
                        end
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bsi_vld = 1'b0;
        rst     = 1'b0;
        #1;
        for (int g = 0; g < 3; g++) begin
            check($sformatf("rst_vld[%0d]", g), 32'(vld_w[g]), 32'd0);
            check($sformatf("rst_cnt[%0d]", g), 32'(cnt_w[g]), 32'd0);
            check($sformatf("rst_rdy[%0d]", g), 32'(rdy_w[g]), 32'd0);
            check($sformatf("rst_sof[%0d]", g), 32'(sof_w[g]), 32'd0);
            check($sformatf("rst_eow[%0d]", g), 32'(eow_w[g]), 32'd0);
        end
        model_reset();
        repeat (3) tick();
        rst = 1'b1;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        bit done;
        done    = 1'b0;
        bsi_adr = a;
        bsi_dat = d;
        bsi_vld = 1'b1;
        for (int c = 0; c < 200 && !done; c++) begin
            if (rdy_w[0]) done = 1'b1;
            tick();
        end
        bsi_vld = 1'b0;
        if (!done) begin
            n_vec++;
            n_bad++;
            $display("FAIL write_timeout: adr 0x%0h never accepted, want acceptance", a);
        end
    endtask

    task automatic drain();
        bit ok;
        ok      = 1'b0;
        bsi_vld = 1'b0;
        str_rdy = 1'b1;
        for (int c = 0; c < 200 && !ok; c++) begin
            if (exp_q[0].size() == 0 && exp_q[1].size() == 0 && exp_q[2].size() == 0 &&
                cnt_w[0] == 0 && cnt_w[1] == 0 && cnt_w[2] == 0)
                ok = 1'b1;
            else
                tick();
        end
        check("drain_empty", 32'(ok), 32'd1);
    endtask

    initial begin
        int  base;
        bit  acc;
        #2;
        do_reset();

        // single word, continuous ready
        str_rdy = 1'b1;
        bus_write(32'd0, 32'h44332211);
        drain();

        // fill while stalled, fifth word waits for space
        base    = chunks_out[0];
        str_rdy = 1'b0;
        fork
            for (int a = 0; a < 5; a++) bus_write(32'(a), $urandom);
            begin
                repeat (12) tick();
                check("full_cnt", 32'(cnt_w[0]), 32'd4);
                check("full_rdy", 32'(rdy_w[0]), 32'd0);
                str_rdy = 1'b1;
            end
        join
        drain();
        check("burst_chunks", 32'(chunks_out[0] - base), 32'd20);

        // address discontinuity and wrap
        str_rdy = 1'b1;
        bus_write(32'd0, 32'hA0A1A2A3);
        bus_write(32'd1, 32'hB0B1B2B3);
        bus_write(32'd5, 32'hC0C1C2C3);
        bus_write(32'd6, 32'hD0D1D2D3);
        bus_write(32'hFFFFFFFF, 32'hE0E1E2E3);
        bus_write(32'h00000000, 32'hF0F1F2F3);
        drain();

        // alternating ready while one word is streamed
        str_rdy = 1'b0;
        bus_write(32'd7, 32'hDDCCBBAA);
        base = chunks_out[0];
        for (int c = 0; c < 8; c++) begin
            str_rdy = (c % 2 == 0);
            tick();
        end
        check("toggle_chunks", 32'(chunks_out[0] - base), 32'd4);
        drain();

        // reset in the middle of a word with a second word queued
        str_rdy = 1'b0;
        bus_write(32'd20, 32'h11112222);
        bus_write(32'd21, 32'h33334444);
        str_rdy = 1'b1;
        repeat (2) tick();
        str_rdy = 1'b0;
        do_reset();
        bus_write(32'd9, 32'h12345678);
        drain();

        // randomized traffic
        bsi_vld = 1'b0;
        for (int c = 0; c < 800; c++) begin
            if (!bsi_vld || acc) begin
                bsi_vld = ($urandom_range(0, 99) < 60);
                bsi_adr = ($urandom_range(0, 3) == 0) ? $urandom : bsi_adr + 32'd1;
                bsi_dat = $urandom;
            end
            str_rdy = (c % 200 < 100) ? ($urandom_range(0, 99) < 70) : ($urandom_range(0, 99) < 25);
            acc = bsi_vld && rdy_w[0];
            tick();
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

endmodule
